// File: rtl/controle_ula_serial_pkg.sv
// Shared definitions for the serial add/sub sequencer.
// - estado_t : controller FSM states (IDLE, CALC, DONE)
// - OP_SOMA / OP_SUB : encodings of the sum/subtract select input
package controle_ula_serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } estado_t;

  localparam logic OP_SOMA = 1'b0;
  localparam logic OP_SUB  = 1'b1;

endpackage

// File: rtl/controle_ula_serial_somador_fatia.sv
// somador_fatia: SLICE_W-bit combinational ripple adder slice.
// Ports:
//   a_i, b_i  in   SLICE_W  slice operands
//   cin_i     in   1        carry in
//   s_o       out  SLICE_W  slice sum
//   cout_o    out  1        carry out of the slice MSB
module somador_fatia #(
  parameter int SLICE_W = 4
) (
  input  logic [SLICE_W-1:0] a_i,
  input  logic [SLICE_W-1:0] b_i,
  input  logic               cin_i,
  output logic [SLICE_W-1:0] s_o,
  output logic               cout_o
);

  assign {cout_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{SLICE_W{1'b0}}, cin_i};

endmodule

// File: rtl/controle_ula_serial.sv
// controle_ula_serial: accepts one add/sub operation over a valid/ready handshake,
// evaluates it LSB-slice first through a single SLICE_W-bit adder slice over
// N = DATA_W/SLICE_W cycles (carry registered between slices) and presents the
// result with Overflow/Carry/Zero/Negative flags until the consumer takes it.
// Ports:
//   Clock, Reset_n (async, active-low), Clear (sync abort to IDLE)
//   In_Valid / In_Ready, Operand_A, Operand_B, Seletion_Sum_Sub (0 sum, 1 sub)
//   Out_Valid / Out_Ready, Result, Overflow, Carry, Zero, Negative, Busy
module controle_ula_serial
  import controle_ula_serial_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int SLICE_W = 4
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              Clear,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic [DATA_W-1:0] Operand_A,
  input  logic [DATA_W-1:0] Operand_B,
  input  logic              Seletion_Sum_Sub,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic [DATA_W-1:0] Result,
  output logic              Overflow,
  output logic              Carry,
  output logic              Zero,
  output logic              Negative,
  output logic              Busy
);

  localparam int N     = DATA_W / SLICE_W;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] ULTIMO = IDX_W'(N - 1);

  estado_t           estado_q, estado_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              carry_q, carry_d;
  logic              sub_q, sub_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;       // B already inverted for subtraction
  logic [DATA_W-1:0] result_q, result_d;
  logic              zacc_q, zacc_d;
  logic              ovf_q, ovf_d;
  logic              cout_q, cout_d;
  logic              zero_q, zero_d;
  logic              neg_q, neg_d;

  logic [SLICE_W-1:0] fatia_a, fatia_b, fatia_s;
  logic               fatia_cout;
  int                 base;

  // Signed overflow from operand and result sign bits; b_msb is the original B.
  function automatic logic calc_ovf(input logic a_msb, input logic b_msb,
                                    input logic r_msb, input logic sub);
    if (sub == OP_SOMA) return (a_msb == b_msb) && (r_msb != a_msb);
    else                return (a_msb != b_msb) && (r_msb == b_msb);
  endfunction

  always_comb begin
    base    = int'(idx_q) * SLICE_W;
    fatia_a = a_q[base +: SLICE_W];
    fatia_b = b_q[base +: SLICE_W];
  end

  somador_fatia #(.SLICE_W(SLICE_W)) u_fatia (
    .a_i   (fatia_a),
    .b_i   (fatia_b),
    .cin_i (carry_q),
    .s_o   (fatia_s),
    .cout_o(fatia_cout)
  );

  always_comb begin
    estado_d = estado_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    sub_d    = sub_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    zacc_d   = zacc_q;
    ovf_d    = ovf_q;
    cout_d   = cout_q;
    zero_d   = zero_q;
    neg_d    = neg_q;
    if (Clear) begin
      // Abort wins over any handshake; result and flags are deliberately kept.
      estado_d = IDLE;
      idx_d    = '0;
      carry_d  = 1'b0;
    end else begin
      unique case (estado_q)
        IDLE: begin
          if (In_Valid) begin
            estado_d = CALC;
            a_d      = Operand_A;
            b_d      = Operand_B ^ {DATA_W{Seletion_Sum_Sub}};
            sub_d    = Seletion_Sum_Sub;
            carry_d  = (Seletion_Sum_Sub == OP_SUB);  // the +1 of two's complement
            idx_d    = '0;
            zacc_d   = 1'b1;
          end
        end
        CALC: begin
          result_d[base +: SLICE_W] = fatia_s;
          carry_d = fatia_cout;
          zacc_d  = zacc_q & (fatia_s == '0);
          idx_d   = idx_q + IDX_W'(1);
          if (idx_q == ULTIMO) begin
            estado_d = DONE;
            idx_d    = '0;
            cout_d   = fatia_cout;
            zero_d   = zacc_q & (fatia_s == '0);
            neg_d    = fatia_s[SLICE_W-1];
            ovf_d    = calc_ovf(a_q[DATA_W-1], b_q[DATA_W-1] ^ sub_q,
                                fatia_s[SLICE_W-1], sub_q);
          end
        end
        DONE: begin
          if (Out_Ready) estado_d = IDLE;
        end
        default: estado_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      estado_q <= IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      sub_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      zacc_q   <= 1'b0;
      ovf_q    <= 1'b0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
    end else begin
      estado_q <= estado_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      sub_q    <= sub_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      zacc_q   <= zacc_d;
      ovf_q    <= ovf_d;
      cout_q   <= cout_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
    end
  end

  assign In_Ready  = (estado_q == IDLE);
  assign Out_Valid = (estado_q == DONE);
  assign Busy      = (estado_q != IDLE);
  assign Result    = result_q;
  assign Overflow  = ovf_q;
  assign Carry     = cout_q;
  assign Zero      = zero_q;
  assign Negative  = neg_q;

endmodule

// File: tb/tb_controle_ula_serial.sv
module tb_controle_ula_serial;

  localparam int DATA_W  = 16;
  localparam int SLICE_W = 4;
  localparam int NSL     = DATA_W / SLICE_W;

  logic              Clock = 1'b0;
  logic              Reset_n = 1'b0;
  logic              Clear = 1'b0;
  logic              In_Valid = 1'b0;
  logic              In_Ready;
  logic [DATA_W-1:0] Operand_A = '0;
  logic [DATA_W-1:0] Operand_B = '0;
  logic              Seletion_Sum_Sub = 1'b0;
  logic              Out_Valid;
  logic              Out_Ready = 1'b0;
  logic [DATA_W-1:0] Result;
  logic              Overflow, Carry, Zero, Negative, Busy;

  int n_cmp  = 0;
  int n_fail = 0;

  controle_ula_serial #(.DATA_W(DATA_W), .SLICE_W(SLICE_W)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .Clear(Clear),
    .In_Valid(In_Valid), .In_Ready(In_Ready),
    .Operand_A(Operand_A), .Operand_B(Operand_B),
    .Seletion_Sum_Sub(Seletion_Sum_Sub),
    .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
    .Result(Result), .Overflow(Overflow), .Carry(Carry),
    .Zero(Zero), .Negative(Negative), .Busy(Busy)
  );

  always #5 Clock = ~Clock;

  // Reference: {Result, Overflow, Carry, Zero, Negative} from plain integer arithmetic.
  function automatic logic [DATA_W+3:0] model_op(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b,
                                                  input logic sub);
    int sa, sb, ua, ub, exact;
    logic [DATA_W-1:0] r;
    logic ovf, c;
    sa = int'($signed(a));
    sb = int'($signed(b));
    ua = int'(a);
    ub = int'(b);
    exact = sub ? sa - sb : sa + sb;
    ovf = (exact > 32767) || (exact < -32768);
    c   = sub ? (ua >= ub) : ((ua + ub) > 65535);
    r   = sub ? DATA_W'(ua - ub) : DATA_W'(ua + ub);
    return {r, ovf, c, (r == '0), r[DATA_W-1]};
  endfunction

  function automatic logic [DATA_W+3:0] observed();
    return {Result, Overflow, Carry, Zero, Negative};
  endfunction

  // Presents one operation for the accept edge and waits for Out_Valid; lat = edges
  // from accept to first Out_Valid, or -1 if it never rises. Called away from an edge.
  task automatic issue_op(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                          input logic sub, output int lat);
    Operand_A = a; Operand_B = b; Seletion_Sum_Sub = sub; In_Valid = 1'b1;
    @(posedge Clock); #1;
    In_Valid = 1'b0;
    Operand_A = DATA_W'($urandom); Operand_B = DATA_W'($urandom);
    Seletion_Sum_Sub = 1'($urandom);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      if (Out_Valid) break;
      @(posedge Clock); #1;
      if (Out_Valid) begin lat = i; break; end
    end
  endtask

  task automatic consume();
    Out_Ready = 1'b1;
    @(posedge Clock); #1;
    Out_Ready = 1'b0;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    #2;
    n_cmp++;
    if ({In_Ready, Out_Valid, Busy, observed()} !== {3'b100, 20'h0}) begin
      n_fail++;
      $display("FAIL reset_state: got rdy/vld/busy=%b res/flags=%h, want 100 / 00000",
               {In_Ready, Out_Valid, Busy}, observed());
    end
    @(posedge Clock); #1;
    Reset_n = 1'b1;
    @(posedge Clock); #1;
  endtask

  task automatic test_directed();
    logic [DATA_W-1:0] ta[5] = '{16'h7FFF, 16'h8000, 16'h0003, 16'h1234, 16'hFFFF};
    logic [DATA_W-1:0] tb[5] = '{16'h0001, 16'h0001, 16'h0005, 16'h1234, 16'h0001};
    logic              ts[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [DATA_W+3:0] te[5] = '{{16'h8000, 4'b1001}, {16'h7FFF, 4'b1100},
                                 {16'hFFFE, 4'b0001}, {16'h0000, 4'b0110},
                                 {16'h0000, 4'b0110}};
    int lat;
    for (int i = 0; i < 5; i++) begin
      issue_op(ta[i], tb[i], ts[i], lat);
      n_cmp++;
      if (lat !== NSL) begin
        n_fail++;
        $display("FAIL directed_latency[%0d]: got %0d edges, want %0d", i, lat, NSL);
      end
      n_cmp++;
      if (observed() !== te[i]) begin
        n_fail++;
        $display("FAIL directed_result[%0d]: got %h, want %h", i, observed(), te[i]);
      end
      consume();
      n_cmp++;
      if ({Out_Valid, In_Ready, Busy} !== 3'b010) begin
        n_fail++;
        $display("FAIL directed_handshake[%0d]: vld/rdy/busy got %b want 010", i,
                 {Out_Valid, In_Ready, Busy});
      end
    end
  endtask

  task automatic test_stall();
    logic [DATA_W+3:0] exp;
    int lat;
    exp = model_op(16'h4321, 16'h1111, 1'b1);
    issue_op(16'h4321, 16'h1111, 1'b1, lat);
    for (int c = 0; c < 5; c++) begin
      In_Valid = c[0];
      Operand_A = 16'h0001; Operand_B = 16'h0001;
      @(posedge Clock); #1;
      n_cmp++;
      if ({Out_Valid, In_Ready, observed()} !== {2'b10, exp}) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: vld/rdy=%b res=%h, want 10 res=%h", c,
                 {Out_Valid, In_Ready}, observed(), exp);
      end
    end
    In_Valid = 1'b0;
    consume();
    n_cmp++;
    if ({Out_Valid, In_Ready, observed()} !== {2'b01, exp}) begin
      n_fail++;
      $display("FAIL stall_release: vld/rdy=%b res=%h, want 01 res=%h",
               {Out_Valid, In_Ready}, observed(), exp);
    end
    @(posedge Clock); #1;
    n_cmp++;
    if (Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_no_queue: Busy got %b want 0", Busy);
    end
  endtask

  task automatic test_clear();
    logic [DATA_W+3:0] exp;
    int lat;
    int seen;
    // Clear during the second CALC cycle with In_Valid held high.
    Operand_A = 16'h0005; Operand_B = 16'h0007; Seletion_Sum_Sub = 1'b0; In_Valid = 1'b1;
    @(posedge Clock); #1;
    @(posedge Clock); #1;
    Clear = 1'b1;
    @(posedge Clock); #1;
    n_cmp++;
    if ({Busy, In_Ready, Out_Valid} !== 3'b010) begin
      n_fail++;
      $display("FAIL clear_calc: busy/rdy/vld got %b want 010", {Busy, In_Ready, Out_Valid});
    end
    Clear = 1'b0; In_Valid = 1'b0;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge Clock); #1;
      if (Out_Valid) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL clear_no_valid: Out_Valid high %0d cycles, want 0", seen);
    end
    issue_op(16'h0001, 16'h0001, 1'b0, lat);
    n_cmp++;
    if ({lat, observed()} !== {NSL, 16'h0002, 4'b0000}) begin
      n_fail++;
      $display("FAIL clear_next_op: lat=%0d res=%h, want %0d res=00020", lat, observed(), NSL);
    end
    // Clear in DONE beats Out_Ready and In_Valid; result stays.
    exp = observed();
    Clear = 1'b1; Out_Ready = 1'b1; In_Valid = 1'b1;
    @(posedge Clock); #1;
    Out_Ready = 1'b0;
    n_cmp++;
    if ({Out_Valid, Busy, observed()} !== {2'b00, exp}) begin
      n_fail++;
      $display("FAIL clear_done: vld/busy=%b res=%h, want 00 res=%h",
               {Out_Valid, Busy}, observed(), exp);
    end
    // Still clearing in IDLE with In_Valid high: no accept.
    @(posedge Clock); #1;
    n_cmp++;
    if (Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_idle: Busy got %b want 0", Busy);
    end
    Clear = 1'b0; In_Valid = 1'b0;
  endtask

  task automatic test_reset_mid_calc();
    int lat;
    Operand_A = 16'h7FFF; Operand_B = 16'h0001; Seletion_Sum_Sub = 1'b0; In_Valid = 1'b1;
    @(posedge Clock); #1;
    In_Valid = 1'b0;
    @(posedge Clock); #1;
    @(posedge Clock); #1;
    Reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({In_Ready, Out_Valid, Busy, observed()} !== {3'b100, 20'h0}) begin
      n_fail++;
      $display("FAIL reset_mid_calc: rdy/vld/busy=%b res=%h, want 100 / 00000",
               {In_Ready, Out_Valid, Busy}, observed());
    end
    @(posedge Clock); #1;
    Reset_n = 1'b1;
    @(posedge Clock); #1;
    n_cmp++;
    if ({Out_Valid, Busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_release: vld/busy got %b want 00", {Out_Valid, Busy});
    end
    issue_op(16'h00FF, 16'h0F01, 1'b0, lat);
    n_cmp++;
    if ({lat, observed()} !== {NSL, model_op(16'h00FF, 16'h0F01, 1'b0)}) begin
      n_fail++;
      $display("FAIL reset_after_op: lat=%0d res=%h, want %0d res=%h", lat, observed(), NSL,
               model_op(16'h00FF, 16'h0F01, 1'b0));
    end
    consume();
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] a, b;
    logic s;
    int lat;
    for (int i = 0; i < 6; i++) begin
      a = DATA_W'($urandom); b = DATA_W'($urandom); s = 1'($urandom);
      issue_op(a, b, s, lat);
      n_cmp++;
      if ({lat, observed()} !== {NSL, model_op(a, b, s)}) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: %h %s %h lat=%0d res=%h, want %0d res=%h", i, a,
                 s ? "-" : "+", b, lat, observed(), NSL, model_op(a, b, s));
      end
      consume();
    end
  endtask

  task automatic test_random();
    logic [DATA_W-1:0] a, b;
    logic s;
    int lat;
    int bad = 0;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0: begin a = 16'h7FFF; b = DATA_W'($urandom); end
        1: begin a = 16'h8000; b = DATA_W'($urandom); end
        2: begin a = DATA_W'($urandom); b = a; end
        default: begin a = DATA_W'($urandom); b = DATA_W'($urandom); end
      endcase
      s = 1'($urandom);
      issue_op(a, b, s, lat);
      n_cmp++;
      if ({lat, observed()} !== {NSL, model_op(a, b, s)}) begin
        n_fail++;
        if (bad < 10)
          $display("FAIL random[%0d]: %h %s %h lat=%0d res=%h, want %0d res=%h", i, a,
                   s ? "-" : "+", b, lat, observed(), NSL, model_op(a, b, s));
        bad++;
      end
      repeat ($urandom_range(0, 3)) begin
        @(posedge Clock); #1;
      end
      consume();
      repeat ($urandom_range(0, 1)) begin
        @(posedge Clock); #1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_clear();
    test_reset_mid_calc();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
